mc_sequencer: RTL and testbench

//  Multicycle control FSM for the single-memory MIPS datapath. Replaces single-cycle decode.

---
 rtl/mc_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer for a single-memory MIPS datapath.
// Moore/Mealy mix: strobes decode from the current state, op/funct and the memory handshake.
module mc_sequencer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       ir_wen,
   output logic       pc_wen,
   output logic [1:0] pc_src,
   output logic       mem_ren,
   output logic       mem_wen,
   output logic       rf_wen,
   output logic       rf_dst,
   output logic       data_rf,
   output logic       alu_src,
   output logic [3:0] alu_ctl,
   output logic [2:0] state,
   output logic       instr_done,
   output logic       illegal,
   output logic       bus_err
);

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_reg, state_next;
   logic [7:0] wait_reg, wait_next;
   logic       bus_err_reg;
   logic       mem_phase;
   logic       timeout_hit;
   logic       legal;
   logic [3:0] alu_op;

   // Legality check covers both the opcode and, for R-type, the function field.
   always_comb begin
      legal = 1'b0;
      case (op)
         OP_R: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
               default:                               legal = 1'b0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      alu_op = ALU_ADD;
      if (op == OP_R) begin
         case (funct)
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
         endcase
      end else if (op == OP_BEQ || op == OP_BNE) begin
         alu_op = ALU_SUB;
      end
   end

   // A ready on the final allowed wait cycle still completes the access.
   assign mem_phase   = (state_reg == S_FETCH) || (state_reg == S_MEM);
   assign timeout_hit = mem_phase && !mem_ready && (wait_reg == WAIT_LAST);
   assign wait_next   = (mem_phase && !mem_ready) ? wait_reg + 8'd1 : 8'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= S_BOOT;
         wait_reg    <= 8'd0;
         bus_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         wait_reg  <= wait_next;
         if (timeout_hit) begin
            bus_err_reg <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ir_wen     = 1'b0;
      pc_wen     = 1'b0;
      pc_src     = 2'b00;
      mem_ren    = 1'b0;
      mem_wen    = 1'b0;
      rf_wen     = 1'b0;
      rf_dst     = 1'b0;
      data_rf    = 1'b0;
      alu_src    = 1'b0;
      alu_ctl    = 4'b0000;
      instr_done = 1'b0;
      illegal    = 1'b0;
      // Strobes are forced low combinationally while rst is high so a write cannot straddle reset.
      if (!rst) begin
         case (state_reg)
            S_BOOT: state_next = S_FETCH;
            S_FETCH: begin
               mem_ren = 1'b1;
               if (mem_ready) begin
                  ir_wen     = 1'b1;
                  pc_wen     = 1'b1;
                  state_next = S_DECODE;
               end else if (timeout_hit) begin
                  state_next = S_HALT;
               end
            end
            S_DECODE: begin
               if (!legal) begin
                  illegal    = 1'b1;
                  state_next = S_FETCH;
               end else if (op == OP_J) begin
                  pc_wen     = 1'b1;
                  pc_src     = 2'b10;
                  instr_done = 1'b1;
                  state_next = S_FETCH;
               end else begin
                  state_next = S_EXEC;
               end
            end
            S_EXEC: begin
               alu_ctl = alu_op;
               case (op)
                  OP_R:    state_next = S_WB;
                  OP_ADDI: begin
                     alu_src    = 1'b1;
                     state_next = S_WB;
                  end
                  OP_LW, OP_SW: begin
                     alu_src    = 1'b1;
                     state_next = S_MEM;
                  end
                  OP_BEQ, OP_BNE: begin
                     pc_src     = 2'b01;
                     pc_wen     = (op == OP_BEQ) ? alu_zero : !alu_zero;
                     instr_done = 1'b1;
                     state_next = S_FETCH;
                  end
                  default: state_next = S_FETCH;
               endcase
            end
            S_MEM: begin
               alu_src = 1'b1;
               alu_ctl = ALU_ADD;
               if (op == OP_SW) begin
                  mem_wen = 1'b1;
               end else begin
                  mem_ren = 1'b1;
               end
               if (mem_ready) begin
                  if (op == OP_SW) begin
                     instr_done = 1'b1;
                     state_next = S_FETCH;
                  end else begin
                     state_next = S_WB;
                  end
               end else if (timeout_hit) begin
                  state_next = S_HALT;
               end
            end
            S_WB: begin
               rf_wen     = 1'b1;
               instr_done = 1'b1;
               alu_ctl    = alu_op;
               alu_src    = (op != OP_R);
               rf_dst     = (op == OP_R);
               data_rf    = (op == OP_LW);
               state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_BOOT;
         endcase
      end
   end

   assign state   = state_reg;
   assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed scoreboard bench for mc_sequencer: stimulus queues per-cycle expected
// strobe vectors, a negedge monitor pops and compares them.
module tb_mc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       alu_zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       ir_wen, pc_wen, mem_ren, mem_wen, rf_wen, rf_dst, data_rf, alu_src;
   logic [1:0] pc_src;
   logic [3:0] alu_ctl;
   logic [2:0] state;
   logic       instr_done, illegal, bus_err;

   int errors = 0;
   int checks = 0;
   logic [19:0] exp_q[$];
   string       name_q[$];

   localparam logic [5:0] R = 6'h00, ADDI = 6'h08, LW = 6'h23, SW = 6'h2B;
   localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, J = 6'h02;
   localparam logic [3:0] AND_C = 4'b0000, OR_C = 4'b0001, ADD_C = 4'b0010;
   localparam logic [3:0] SUB_C = 4'b0110, SLT_C = 4'b0111;

   mc_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .ir_wen(ir_wen), .pc_wen(pc_wen), .pc_src(pc_src),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .rf_wen(rf_wen), .rf_dst(rf_dst),
      .data_rf(data_rf), .alu_src(alu_src), .alu_ctl(alu_ctl), .state(state),
      .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] mk(input logic [2:0] st, input logic irw, input logic pcw,
                                      input logic [1:0] src, input logic ren, input logic wen,
                                      input logic rfw, input logic dst, input logic drf,
                                      input logic asrc, input logic [3:0] actl,
                                      input logic done, input logic ill, input logic berr);
      return {st, irw, pcw, src, ren, wen, rfw, dst, drf, asrc, actl, done, ill, berr};
   endfunction

   task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic rdy, input logic z, input logic [19:0] e, input string nm);
      @(posedge clk);
      #1;
      rst = r; op = o; funct = f; mem_ready = rdy; alu_zero = z;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic fetch_ok(input logic [5:0] o, input logic [5:0] f, input string nm);
      step(0, o, f, 1, 0, mk(3'd1, 1, 1, 2'b00, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0), {nm, " fetch"});
   endtask

   task automatic decode_plain(input logic [5:0] o, input logic [5:0] f, input string nm);
      step(0, o, f, 0, 0, mk(3'd2, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0), {nm, " decode"});
   endtask

   // Monitor: every sampled cycle with a queued expectation is one comparison.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [19:0] e, a;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {state, ir_wen, pc_wen, pc_src, mem_ren, mem_wen, rf_wen, rf_dst, data_rf,
               alu_src, alu_ctl, instr_done, illegal, bus_err};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h (state %0d vs %0d)", nm, a, e, a[19:17], e[19:17]);
         end else begin
            $display("check %0d %s ok: outputs %05h", checks, nm, a);
         end
      end
   end

   initial begin
      logic [5:0] fn_tab[4];
      logic [3:0] alu_tab[4];
      logic [5:0] br_op[4];
      logic       br_z[4];
      logic       br_pc[4];
      fn_tab  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
      alu_tab = '{SUB_C, AND_C, OR_C, SLT_C};
      br_op   = '{BEQ, BEQ, BNE, BNE};
      br_z    = '{1'b1, 1'b0, 1'b1, 1'b0};
      br_pc   = '{1'b1, 1'b0, 1'b0, 1'b1};

      repeat (3) step(1, R, 6'd0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0), "reset");
      step(0, R, 6'd0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0), "boot");

      // add: 4 cycles
      fetch_ok(R, 6'b100000, "add");
      decode_plain(R, 6'b100000, "add");
      step(0, R, 6'b100000, 1, 0, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADD_C, 0, 0, 0), "add exec");
      step(0, R, 6'b100000, 1, 0, mk(3'd5, 0, 0, 0, 0, 0, 1, 1, 0, 0, ADD_C, 1, 0, 0), "add wb");

      for (int i = 0; i < 4; i++) begin
         fetch_ok(R, fn_tab[i], "rtype");
         decode_plain(R, fn_tab[i], "rtype");
         step(0, R, fn_tab[i], 1, 0, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, alu_tab[i], 0, 0, 0), "rtype exec");
         step(0, R, fn_tab[i], 1, 0, mk(3'd5, 0, 0, 0, 0, 0, 1, 1, 0, 0, alu_tab[i], 1, 0, 0), "rtype wb");
      end

      fetch_ok(ADDI, 6'd0, "addi");
      decode_plain(ADDI, 6'd0, "addi");
      step(0, ADDI, 6'd0, 1, 0, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1, ADD_C, 0, 0, 0), "addi exec");
      step(0, ADDI, 6'd0, 1, 0, mk(3'd5, 0, 0, 0, 0, 0, 1, 0, 0, 1, ADD_C, 1, 0, 0), "addi wb");

      // lw: fetch ready arrives on the 4th cycle (timeout boundary), MEM waits 3 then ready
      repeat (3) step(0, LW, 6'd0, 0, 0, mk(3'd1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0), "lw fetch wait");
      fetch_ok(LW, 6'd0, "lw boundary");
      decode_plain(LW, 6'd0, "lw");
      step(0, LW, 6'd0, 0, 0, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1, ADD_C, 0, 0, 0), "lw exec");
      repeat (3) step(0, LW, 6'd0, 0, 0, mk(3'd4, 0, 0, 0, 1, 0, 0, 0, 0, 1, ADD_C, 0, 0, 0), "lw mem wait");
      step(0, LW, 6'd0, 1, 0, mk(3'd4, 0, 0, 0, 1, 0, 0, 0, 0, 1, ADD_C, 0, 0, 0), "lw mem ready");
      step(0, LW, 6'd0, 0, 0, mk(3'd5, 0, 0, 0, 0, 0, 1, 0, 1, 1, ADD_C, 1, 0, 0), "lw wb");

      fetch_ok(SW, 6'd0, "sw");
      decode_plain(SW, 6'd0, "sw");
      step(0, SW, 6'd0, 1, 0, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1, ADD_C, 0, 0, 0), "sw exec");
      step(0, SW, 6'd0, 1, 0, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 1, ADD_C, 1, 0, 0), "sw mem");

      for (int i = 0; i < 4; i++) begin
         fetch_ok(br_op[i], 6'd0, "branch");
         decode_plain(br_op[i], 6'd0, "branch");
         step(0, br_op[i], 6'd0, 1, br_z[i],
              mk(3'd3, 0, br_pc[i], 2'b01, 0, 0, 0, 0, 0, 0, SUB_C, 1, 0, 0), "branch exec");
      end

      fetch_ok(J, 6'd0, "j");
      step(0, J, 6'd0, 1, 0, mk(3'd2, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 4'd0, 1, 0, 0), "j decode");

      fetch_ok(6'h3F, 6'd0, "bad op");
      step(0, 6'h3F, 6'd0, 1, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 0), "bad op decode");
      fetch_ok(R, 6'b100001, "bad funct");
      step(0, R, 6'b100001, 1, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 0), "bad funct decode");

      // reset in the middle of a stalled store
      fetch_ok(SW, 6'd0, "sw rst");
      decode_plain(SW, 6'd0, "sw rst");
      step(0, SW, 6'd0, 0, 0, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1, ADD_C, 0, 0, 0), "sw rst exec");
      step(0, SW, 6'd0, 0, 0, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 1, ADD_C, 0, 0, 0), "sw rst mem");
      step(1, SW, 6'd0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0), "rst mid mem");
      step(0, SW, 6'd0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0), "boot again");

      // store timeout: 4 stalled MEM cycles, then HALT with sticky bus_err
      fetch_ok(SW, 6'd0, "sw to");
      decode_plain(SW, 6'd0, "sw to");
      step(0, SW, 6'd0, 0, 0, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1, ADD_C, 0, 0, 0), "sw to exec");
      repeat (4) step(0, SW, 6'd0, 0, 0, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 1, ADD_C, 0, 0, 0), "sw to mem");
      step(0, SW, 6'd0, 0, 0, mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1), "halt");
      step(0, SW, 6'd0, 1, 0, mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1), "halt stays");
      step(1, SW, 6'd0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0), "rst clears err");
      step(0, SW, 6'd0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0), "boot after err");
      fetch_ok(R, 6'b100000, "post err");

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
